// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer_pkg
// Brief  : Shared default geometry for the reorder buffer and its pointers.
// Rev    : 1.0  initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int c_ROB_DEPTH    = 16;
    localparam int c_ROB_TAG_W    = 4;
    localparam int c_ROB_NAME_W   = 5;
    localparam int c_ROB_DATA_W   = 32;
    localparam int c_ROB_WB_PORTS = 2;
    localparam int c_ROB_LOOKUPS  = 2;

endpackage : reorder_buffer_pkg
`default_nettype wire

// File: rtl/reorder_buffer_ptr.sv
`default_nettype none
// ============================================================================
// Module : rob_ptr
// Brief  : Wrap-bit ring pointer with increment and clear, frozen when !i_en.
// Rev    : 1.0  initial release
// ============================================================================
module rob_ptr
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W = c_ROB_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [TAG_W:0]   o_ptr
);

    logic [TAG_W:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_ptr <= '0;
            end else if (i_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign o_ptr = r_ptr;

endmodule : rob_ptr
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer
// Brief  : In-order retirement buffer; out-of-order writeback, one retire/cycle,
//          redirect on retire flushes the whole buffer.
// Rev    : 1.0  initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH    = c_ROB_DEPTH,
    parameter int TAG_W    = c_ROB_TAG_W,
    parameter int NAME_W   = c_ROB_NAME_W,
    parameter int DATA_W   = c_ROB_DATA_W,
    parameter int WB_PORTS = c_ROB_WB_PORTS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         alloc_en,
    input  logic [NAME_W-1:0]            alloc_name,
    output logic [TAG_W-1:0]             alloc_tag,
    output logic                         full,
    input  logic [WB_PORTS-1:0]          wb_en,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
    input  logic [WB_PORTS-1:0]          wb_redir,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_target,
    input  logic [2*TAG_W-1:0]           q_tag,
    output logic [1:0]                   q_ready,
    output logic [2*DATA_W-1:0]          q_data,
    output logic                         commit_en,
    output logic [NAME_W-1:0]            commit_name,
    output logic [TAG_W-1:0]             commit_tag,
    output logic [DATA_W-1:0]            commit_data,
    output logic                         flush_en,
    output logic [DATA_W-1:0]            flush_pc
);

    localparam logic [TAG_W:0] c_FULL_CNT = DEPTH[TAG_W:0];

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_redir;
    logic [NAME_W-1:0] r_name   [DEPTH];
    logic [DATA_W-1:0] r_data   [DEPTH];
    logic [DATA_W-1:0] r_target [DEPTH];

    logic [TAG_W:0]    w_head;
    logic [TAG_W:0]    w_tail;
    logic [TAG_W:0]    w_count;
    logic [TAG_W-1:0]  w_head_idx;
    logic [TAG_W-1:0]  w_tail_idx;
    logic              w_empty;
    logic              w_retire;
    logic              w_flush;
    logic              w_alloc;

    // Count comes from the wrap-bit pointer difference, so full and empty are distinct.
    assign w_count    = w_tail - w_head;
    assign w_head_idx = w_head[TAG_W-1:0];
    assign w_tail_idx = w_tail[TAG_W-1:0];
    assign full       = (w_count == c_FULL_CNT);
    assign w_empty    = (w_count == '0);
    assign alloc_tag  = w_tail_idx;

    assign w_retire = rdy && !w_empty && r_valid[w_head_idx] && r_done[w_head_idx];
    assign w_flush  = w_retire && r_redir[w_head_idx];
    assign w_alloc  = rdy && alloc_en && !full && !w_flush;

    rob_ptr #(.TAG_W(TAG_W)) u_head (
        .clk   (clk),
        .rst   (rst),
        .i_en  (rdy),
        .i_inc (w_retire),
        .i_clr (w_flush),
        .o_ptr (w_head)
    );

    rob_ptr #(.TAG_W(TAG_W)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .i_en  (rdy),
        .i_inc (w_alloc),
        .i_clr (w_flush),
        .o_ptr (w_tail)
    );

    // Later ports override earlier ones on a shared tag; retire and alloc act last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_done  <= '0;
            r_redir <= '0;
        end else if (rdy) begin
            if (w_flush) begin
                r_valid <= '0;
                r_done  <= '0;
                r_redir <= '0;
            end else begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_en[p] && r_valid[wb_tag[p*TAG_W +: TAG_W]]) begin
                        r_done[wb_tag[p*TAG_W +: TAG_W]]   <= 1'b1;
                        r_redir[wb_tag[p*TAG_W +: TAG_W]]  <= wb_redir[p];
                        r_data[wb_tag[p*TAG_W +: TAG_W]]   <= wb_data[p*DATA_W +: DATA_W];
                        r_target[wb_tag[p*TAG_W +: TAG_W]] <= wb_target[p*DATA_W +: DATA_W];
                    end
                end
                if (w_retire) begin
                    r_valid[w_head_idx] <= 1'b0;
                end
                if (w_alloc) begin
                    r_valid[w_tail_idx] <= 1'b1;
                    r_done[w_tail_idx]  <= 1'b0;
                    r_redir[w_tail_idx] <= 1'b0;
                    r_name[w_tail_idx]  <= alloc_name;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_en   <= 1'b0;
            commit_name <= '0;
            commit_tag  <= '0;
            commit_data <= '0;
            flush_en    <= 1'b0;
            flush_pc    <= '0;
        end else begin
            commit_en <= 1'b0;
            flush_en  <= 1'b0;
            if (w_retire) begin
                commit_en   <= 1'b1;
                commit_name <= r_name[w_head_idx];
                commit_tag  <= w_head_idx;
                commit_data <= r_data[w_head_idx];
                if (r_redir[w_head_idx]) begin
                    flush_en <= 1'b1;
                    flush_pc <= r_target[w_head_idx];
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_lookup
            assign q_ready[i]                = r_valid[q_tag[i*TAG_W +: TAG_W]] && r_done[q_tag[i*TAG_W +: TAG_W]];
            assign q_data[i*DATA_W +: DATA_W] = r_data[q_tag[i*TAG_W +: TAG_W]];
        end
    endgenerate

endmodule : reorder_buffer
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_reorder_buffer
// Brief  : Directed scenarios plus random traffic against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int NAME_W = 5;
    localparam int DATA_W = 32;
    localparam int WBP    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     rdy;
    logic                     alloc_en;
    logic [NAME_W-1:0]        alloc_name;
    logic [TAG_W-1:0]         alloc_tag;
    logic                     full;
    logic [WBP-1:0]           wb_en;
    logic [WBP*TAG_W-1:0]     wb_tag;
    logic [WBP*DATA_W-1:0]    wb_data;
    logic [WBP-1:0]           wb_redir;
    logic [WBP*DATA_W-1:0]    wb_target;
    logic [2*TAG_W-1:0]       q_tag;
    logic [1:0]               q_ready;
    logic [2*DATA_W-1:0]      q_data;
    logic                     commit_en;
    logic [NAME_W-1:0]        commit_name;
    logic [TAG_W-1:0]         commit_tag;
    logic [DATA_W-1:0]        commit_data;
    logic                     flush_en;
    logic [DATA_W-1:0]        flush_pc;

    reorder_buffer #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .NAME_W(NAME_W), .DATA_W(DATA_W), .WB_PORTS(WBP)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_en(alloc_en), .alloc_name(alloc_name), .alloc_tag(alloc_tag), .full(full),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .wb_redir(wb_redir), .wb_target(wb_target),
        .q_tag(q_tag), .q_ready(q_ready), .q_data(q_data),
        .commit_en(commit_en), .commit_name(commit_name), .commit_tag(commit_tag),
        .commit_data(commit_data), .flush_en(flush_en), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: program-order queue of live tags plus per-tag result records.
    int                order[$];
    int                m_tail;
    bit                m_done   [DEPTH];
    bit                m_redir  [DEPTH];
    logic [NAME_W-1:0] m_name   [DEPTH];
    logic [DATA_W-1:0] m_data   [DEPTH];
    logic [DATA_W-1:0] m_target [DEPTH];

    function automatic bit m_live(input int t);
        foreach (order[i]) if (order[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        order.delete();
        m_tail = 0;
        for (int t = 0; t < DEPTH; t++) begin
            m_done[t]  = 1'b0;
            m_redir[t] = 1'b0;
        end
    endtask

    task automatic idle();
        rst        = 1'b1;
        rdy        = 1'b1;
        alloc_en   = 1'b0;
        alloc_name = '0;
        wb_en      = '0;
        wb_redir   = '0;
        wb_tag     = '0;
        wb_data    = '0;
        wb_target  = '0;
        q_tag      = 8'($urandom);
    endtask

    task automatic wb(input int p, input int tag, input logic [31:0] d, input bit rd, input logic [31:0] tgt);
        wb_en[p]                     = 1'b1;
        wb_tag[p*TAG_W +: TAG_W]     = 4'(tag);
        wb_data[p*DATA_W +: DATA_W]  = d;
        wb_redir[p]                  = rd;
        wb_target[p*DATA_W +: DATA_W] = tgt;
    endtask

    task automatic alloc(input logic [NAME_W-1:0] nm);
        alloc_en   = 1'b1;
        alloc_name = nm;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit                e_ce;
        bit                e_fe;
        bit                was_rst;
        bit                retire;
        bit                r;
        int                pre;
        int                h;
        int                t;
        logic [NAME_W-1:0] e_name;
        int                e_tag;
        logic [DATA_W-1:0] e_data;
        logic [DATA_W-1:0] e_fpc;
        e_ce = 0; e_fe = 0; was_rst = 0; e_name = '0; e_tag = 0; e_data = '0; e_fpc = '0;
        #1;
        chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
        chk("full", 64'(full), 64'(order.size() == DEPTH));
        for (int i = 0; i < 2; i++) begin
            t = int'(q_tag[i*TAG_W +: TAG_W]);
            r = m_live(t) && m_done[t];
            chk("q_ready", 64'(q_ready[i]), 64'(r));
            if (r) chk("q_data", 64'(q_data[i*DATA_W +: DATA_W]), 64'(m_data[t]));
        end
        if (!rst) begin
            was_rst = 1;
            model_clear();
        end else if (rdy) begin
            pre    = order.size();
            retire = (pre > 0) && m_done[order[0]];
            if (retire) begin
                h      = order[0];
                e_ce   = 1;
                e_name = m_name[h];
                e_tag  = h;
                e_data = m_data[h];
                if (m_redir[h]) begin
                    e_fe  = 1;
                    e_fpc = m_target[h];
                end
            end
            if (e_fe) begin
                model_clear();
            end else begin
                for (int p = 0; p < WBP; p++) begin
                    t = int'(wb_tag[p*TAG_W +: TAG_W]);
                    if (wb_en[p] && m_live(t)) begin
                        m_done[t]   = 1'b1;
                        m_redir[t]  = wb_redir[p];
                        m_data[t]   = wb_data[p*DATA_W +: DATA_W];
                        m_target[t] = wb_target[p*DATA_W +: DATA_W];
                    end
                end
                if (retire) void'(order.pop_front());
                if (alloc_en && pre < DEPTH) begin
                    order.push_back(m_tail);
                    m_name[m_tail]  = alloc_name;
                    m_done[m_tail]  = 1'b0;
                    m_redir[m_tail] = 1'b0;
                    m_tail          = (m_tail + 1) % DEPTH;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("commit_en", 64'(commit_en), 64'(e_ce));
        chk("flush_en", 64'(flush_en), 64'(e_fe));
        if (was_rst) begin
            chk("rst_commit_name", 64'(commit_name), 64'd0);
            chk("rst_commit_tag", 64'(commit_tag), 64'd0);
            chk("rst_commit_data", 64'(commit_data), 64'd0);
            chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        end
        if (e_ce) begin
            chk("commit_name", 64'(commit_name), 64'(e_name));
            chk("commit_tag", 64'(commit_tag), 64'(e_tag));
            chk("commit_data", 64'(commit_data), 64'(e_data));
        end
        if (e_fe) chk("flush_pc", 64'(flush_pc), 64'(e_fpc));
    endtask

    task automatic do_reset();
        idle(); rst = 1'b0; step(); step();
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            idle();
            if (order.size() > 0) wb(0, order[0], 32'($urandom), 1'b0, 32'h0);
            if (order.size() > 1) wb(1, order[1], 32'($urandom), 1'b0, 32'h0);
            step();
        end
    endtask

    initial begin
        model_clear();
        idle();

        // Reset
        do_reset();
        chk("t1_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("t1_full", 64'(full), 64'd0);

        // Single alloc/writeback/commit
        idle(); alloc(5'd5); step();
        idle(); wb(0, 0, 32'h1234, 1'b0, 32'h0); step();
        idle(); step();
        chk("t2_commit_en", 64'(commit_en), 64'd1);
        chk("t2_commit_data", 64'(commit_data), 64'h1234);
        chk("t2_commit_name", 64'(commit_name), 64'd5);

        // Out-of-order writeback, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); alloc(5'(i + 1)); step(); end
        idle(); wb(0, 2, 32'h22, 1'b0, 32'h0); step();
        idle(); wb(0, 1, 32'h11, 1'b0, 32'h0); step();
        idle(); wb(0, 0, 32'h00, 1'b0, 32'h0); step();
        for (int i = 0; i < 4; i++) begin idle(); step(); end

        // Fill, overflow attempt, tail wrap, retire with alloc
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin idle(); alloc(5'(i)); step(); end
        chk("t4_full", 64'(full), 64'd1);
        chk("t4_wrap_tag", 64'(alloc_tag), 64'd0);
        idle(); alloc(5'd31); step();
        idle(); wb(0, 0, 32'hA0, 1'b0, 32'h0); step();
        idle(); alloc(5'd30); wb(1, 1, 32'hA1, 1'b0, 32'h0); step();
        idle(); alloc(5'd29); step();
        drain(24);

        // Two ports on the same tag
        do_reset();
        for (int i = 0; i < 4; i++) begin idle(); alloc(5'(i + 8)); step(); end
        idle(); wb(0, 3, 32'hAA, 1'b0, 32'h0); wb(1, 3, 32'hBB, 1'b0, 32'h0); step();
        idle(); wb(0, 0, 32'h1, 1'b0, 32'h0); wb(1, 1, 32'h2, 1'b0, 32'h0); step();
        idle(); wb(0, 2, 32'h3, 1'b0, 32'h0); step();
        idle(); step();
        idle(); step();
        idle(); q_tag = 8'h33; step();
        chk("t5_commit_tag", 64'(commit_tag), 64'd3);
        chk("t5_commit_data", 64'(commit_data), 64'hBB);

        // Redirect flush
        do_reset();
        for (int i = 0; i < 5; i++) begin idle(); alloc(5'(i + 16)); step(); end
        idle(); wb(0, 0, 32'h50, 1'b0, 32'h0); step();
        idle(); wb(0, 1, 32'h51, 1'b1, 32'h100); step();
        idle(); alloc(5'd7); wb(1, 2, 32'h52, 1'b0, 32'h0); step();
        chk("t6_flush_en", 64'(flush_en), 64'd1);
        chk("t6_flush_pc", 64'(flush_pc), 64'h100);
        chk("t6_commit_tag", 64'(commit_tag), 64'd1);
        idle(); wb(0, 3, 32'h53, 1'b0, 32'h0); step();
        idle(); rdy = 1'b0; alloc(5'd9); step();
        idle(); step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) alloc(5'($urandom));
            for (int p = 0; p < WBP; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int tg;
                    if (order.size() > 0 && $urandom_range(0, 4) != 0)
                        tg = order[$urandom_range(0, order.size() - 1)];
                    else
                        tg = int'($urandom_range(0, DEPTH - 1));
                    wb(p, tg, 32'($urandom), ($urandom_range(0, 15) == 0), 32'($urandom));
                end
            end
            if ($urandom_range(0, 499) == 0) rst = 1'b0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reorder_buffer
`default_nettype wire
